// File: rtl/guess_round_ctrl_if.sv
// Bus between the round sequencer, the entry datapath and the display mux.
// The slave side is the sequencer; the master side drives entry/pulses and
// consumes the game status.
interface guess_round_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  i_tick;
   logic                  i_new_game;
   logic                  i_submit;
   logic [4*DIGITS-1:0]   i_entry;
   logic [2:0]            o_state;
   logic                  o_active_player;
   logic                  o_entry_en;
   logic                  o_clear_entry;
   logic [1:0]            o_hint;
   logic [4:0]            o_attempts;
   logic [7:0]            o_attempts_bcd;
   logic [7:0]            o_led;
   logic                  o_game_over;

   modport slave (
      input  i_tick, i_new_game, i_submit, i_entry,
      output o_state, o_active_player, o_entry_en, o_clear_entry,
             o_hint, o_attempts, o_attempts_bcd, o_led, o_game_over
   );

   modport master (
      output i_tick, i_new_game, i_submit, i_entry,
      input  o_state, o_active_player, o_entry_en, o_clear_entry,
             o_hint, o_attempts, o_attempts_bcd, o_led, o_game_over
   );
endinterface

// File: rtl/guess_round_ctrl.sv
// Round sequencer for the two-player code game: P1 commits a secret code,
// P2 guesses it, each guess yields a higher/lower hint and counts an attempt.
// Every status output is registered except the BCD view of the attempt count.
module guess_round_ctrl #(
   parameter int DIGITS      = 4,
   parameter int MAX_TRIES   = 20,
   parameter int BLINK_TICKS = 200
) (
   input  logic                     i_clock,
   input  logic                     i_rst,
   guess_round_ctrl_if.slave        bus
);
   localparam int CW = 4 * DIGITS;
   localparam int TW = (BLINK_TICKS < 2) ? 1 : $clog2(BLINK_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(BLINK_TICKS - 1);
   localparam logic [4:0]    TRIES_LAST = 5'(MAX_TRIES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SET   = 3'd1,
      S_GUESS = 3'd2,
      S_CMP   = 3'd3,
      S_WIN   = 3'd4,
      S_LOSE  = 3'd5
   } state_t;

   state_t          r_state,         w_state_next;
   logic [CW-1:0]   r_secret,        w_secret_next;
   logic [CW-1:0]   r_guess,         w_guess_next;
   logic [4:0]      r_attempts,      w_attempts_next;
   logic [1:0]      r_hint,          w_hint_next;
   logic [7:0]      r_led,           w_led_next;
   logic [TW-1:0]   r_tick_cnt,      w_tick_cnt_next;
   logic            r_clear_entry,   w_clear_entry_next;
   logic            r_entry_en,      w_entry_en_next;
   logic            r_active_player, w_active_player_next;
   logic            r_game_over,     w_game_over_next;

   logic [1:0]      w_tens;
   logic [3:0]      w_units;

   // State and registered outputs; reset wipes the secret along with everything else.
   always_ff @(posedge i_clock) begin
      if (i_rst) begin
         r_state         <= S_IDLE;
         r_secret        <= '0;
         r_guess         <= '0;
         r_attempts      <= '0;
         r_hint          <= '0;
         r_led           <= '0;
         r_tick_cnt      <= '0;
         r_clear_entry   <= 1'b0;
         r_entry_en      <= 1'b0;
         r_active_player <= 1'b0;
         r_game_over     <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_secret        <= w_secret_next;
         r_guess         <= w_guess_next;
         r_attempts      <= w_attempts_next;
         r_hint          <= w_hint_next;
         r_led           <= w_led_next;
         r_tick_cnt      <= w_tick_cnt_next;
         r_clear_entry   <= w_clear_entry_next;
         r_entry_en      <= w_entry_en_next;
         r_active_player <= w_active_player_next;
         r_game_over     <= w_game_over_next;
      end
   end

   // Next-state logic; new_game overrides any submit in the same cycle.
   always_comb begin
      w_state_next       = r_state;
      w_secret_next      = r_secret;
      w_guess_next       = r_guess;
      w_attempts_next    = r_attempts;
      w_hint_next        = r_hint;
      w_led_next         = r_led;
      w_tick_cnt_next    = r_tick_cnt;
      w_clear_entry_next = 1'b0;

      if (bus.i_new_game) begin
         w_state_next       = S_SET;
         w_secret_next      = '0;
         w_guess_next       = '0;
         w_attempts_next    = '0;
         w_hint_next        = 2'b00;
         w_led_next         = 8'h00;
         w_tick_cnt_next    = '0;
         w_clear_entry_next = 1'b1;
      end else begin
         case (r_state)
            S_SET: begin
               // An all-zero secret is refused so P1 must pick a real code.
               if (bus.i_submit) begin
                  w_clear_entry_next = 1'b1;
                  if (bus.i_entry != '0) begin
                     w_secret_next = bus.i_entry;
                     w_state_next  = S_GUESS;
                  end
               end
            end
            S_GUESS: begin
               if (bus.i_submit) begin
                  w_guess_next       = bus.i_entry;
                  w_attempts_next    = (r_attempts == 5'd31) ? 5'd31 : r_attempts + 5'd1;
                  w_clear_entry_next = 1'b1;
                  w_state_next       = S_CMP;
               end
            end
            S_CMP: begin
               // Whole-vector unsigned compare is the same as MS-nibble-first.
               if (r_guess == r_secret) begin
                  w_hint_next     = 2'b11;
                  w_state_next    = S_WIN;
                  w_tick_cnt_next = '0;
                  w_led_next      = 8'h00;
               end else begin
                  w_hint_next = (r_secret > r_guess) ? 2'b01 : 2'b10;
                  if (r_attempts == TRIES_LAST) begin
                     w_state_next = S_LOSE;
                     w_led_next   = 8'h0F;
                  end else begin
                     w_state_next = S_GUESS;
                  end
               end
            end
            S_WIN: begin
               if (bus.i_tick) begin
                  if (r_tick_cnt == TICK_LAST) begin
                     w_tick_cnt_next = '0;
                     w_led_next      = ~r_led;
                  end else begin
                     w_tick_cnt_next = r_tick_cnt + 1'b1;
                  end
               end
            end
            S_LOSE: begin
               w_led_next = 8'h0F;
            end
            default: begin
            end
         endcase
      end

      w_entry_en_next      = (w_state_next == S_SET) || (w_state_next == S_GUESS);
      w_active_player_next = (w_state_next == S_GUESS) || (w_state_next == S_CMP) ||
                             (w_state_next == S_WIN)   || (w_state_next == S_LOSE);
      w_game_over_next     = (w_state_next == S_WIN)   || (w_state_next == S_LOSE);
   end

   // Binary attempts (0..31) split into BCD tens/units for the 7-seg mux.
   always_comb begin
      w_tens  = 2'd0;
      w_units = 4'(r_attempts);
      if (r_attempts >= 5'd30) begin
         w_tens  = 2'd3;
         w_units = 4'(r_attempts - 5'd30);
      end else if (r_attempts >= 5'd20) begin
         w_tens  = 2'd2;
         w_units = 4'(r_attempts - 5'd20);
      end else if (r_attempts >= 5'd10) begin
         w_tens  = 2'd1;
         w_units = 4'(r_attempts - 5'd10);
      end
   end

   assign bus.o_state         = r_state;
   assign bus.o_active_player = r_active_player;
   assign bus.o_entry_en      = r_entry_en;
   assign bus.o_clear_entry   = r_clear_entry;
   assign bus.o_hint          = r_hint;
   assign bus.o_attempts      = r_attempts;
   assign bus.o_attempts_bcd  = {2'b00, w_tens, w_units};
   assign bus.o_led           = r_led;
   assign bus.o_game_over     = r_game_over;
endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for the round sequencer. dut_a plays full games with a short
// blink period; dut_b uses MAX_TRIES=2 to reach LOSE quickly.
module tb_guess_round_ctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   guess_round_ctrl_if #(.DIGITS(4)) bus_a ();
   guess_round_ctrl_if #(.DIGITS(4)) bus_b ();

   guess_round_ctrl #(.DIGITS(4), .MAX_TRIES(20), .BLINK_TICKS(4)) dut_a (
      .i_clock (clk),
      .i_rst   (rst),
      .bus     (bus_a)
   );

   guess_round_ctrl #(.DIGITS(4), .MAX_TRIES(2), .BLINK_TICKS(4)) dut_b (
      .i_clock (clk),
      .i_rst   (rst),
      .bus     (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus_a.i_tick = 0; bus_a.i_new_game = 0; bus_a.i_submit = 0; bus_a.i_entry = '0;
      bus_b.i_tick = 0; bus_b.i_new_game = 0; bus_b.i_submit = 0; bus_b.i_entry = '0;
      cyc(); cyc();
      chk("rst_state",    bus_a.o_state, 3'd0);
      chk("rst_attempts", bus_a.o_attempts, 5'd0);
      chk("rst_bcd",      bus_a.o_attempts_bcd, 8'h00);
      chk("rst_hint",     bus_a.o_hint, 2'b00);
      chk("rst_led",      bus_a.o_led, 8'h00);
      chk("rst_flags",    {bus_a.o_game_over, bus_a.o_entry_en, bus_a.o_active_player, bus_a.o_clear_entry}, 4'b0000);
      rst = 1'b0;
      cyc();

      // 1: new_game, then a zero secret is rejected
      bus_a.i_new_game = 1; cyc(); bus_a.i_new_game = 0;
      chk("ng_state",  bus_a.o_state, 3'd1);
      chk("ng_clear",  bus_a.o_clear_entry, 1'b1);
      chk("ng_en_pl",  {bus_a.o_entry_en, bus_a.o_active_player}, 2'b10);
      bus_a.i_entry = 16'h0000; bus_a.i_submit = 1; cyc(); bus_a.i_submit = 0;
      chk("zero_state", bus_a.o_state, 3'd1);
      chk("zero_clear", bus_a.o_clear_entry, 1'b1);
      cyc();
      chk("clear_pulse_end", bus_a.o_clear_entry, 1'b0);

      // 2: secret 3A51, guess 3A4F -> HI
      bus_a.i_entry = 16'h3A51; bus_a.i_submit = 1; cyc(); bus_a.i_submit = 0;
      chk("set_state",  bus_a.o_state, 3'd2);
      chk("set_player", bus_a.o_active_player, 1'b1);
      bus_a.i_tick = 1; cyc(); bus_a.i_tick = 0;
      chk("tick_guess_led", bus_a.o_led, 8'h00);
      bus_a.i_entry = 16'h3A4F; bus_a.i_submit = 1; cyc(); bus_a.i_submit = 0;
      chk("g1_cmp_state", bus_a.o_state, 3'd3);
      chk("g1_attempts",  bus_a.o_attempts, 5'd1);
      chk("g1_clear",     bus_a.o_clear_entry, 1'b1);
      chk("g1_en",        bus_a.o_entry_en, 1'b0);
      cyc();
      chk("g1_hint",  bus_a.o_hint, 2'b01);
      chk("g1_state", bus_a.o_state, 3'd2);

      // 3: 3A60 -> LO, then 3A51 -> WIN
      bus_a.i_entry = 16'h3A60; bus_a.i_submit = 1; cyc(); bus_a.i_submit = 0;
      cyc();
      chk("g2_hint",  bus_a.o_hint, 2'b10);
      chk("g2_state", bus_a.o_state, 3'd2);
      bus_a.i_entry = 16'h3A51; bus_a.i_submit = 1; cyc(); bus_a.i_submit = 0;
      cyc();
      chk("g3_hint",  bus_a.o_hint, 2'b11);
      chk("g3_state", bus_a.o_state, 3'd4);
      chk("g3_over",  bus_a.o_game_over, 1'b1);
      chk("g3_bcd",   bus_a.o_attempts_bcd, 8'h03);
      chk("g3_en_pl", {bus_a.o_entry_en, bus_a.o_active_player}, 2'b01);

      // 4: blinking in WIN, period 4 ticks
      for (int i = 0; i < 3; i++) begin
         bus_a.i_tick = 1; cyc(); bus_a.i_tick = 0; cyc();
      end
      chk("win_3ticks", bus_a.o_led, 8'h00);
      bus_a.i_tick = 1; cyc(); bus_a.i_tick = 0; cyc();
      chk("win_4ticks", bus_a.o_led, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         bus_a.i_tick = 1; cyc(); bus_a.i_tick = 0; cyc();
      end
      chk("win_8ticks", bus_a.o_led, 8'h00);
      bus_a.i_submit = 1; cyc(); bus_a.i_submit = 0;
      chk("win_submit_state", bus_a.o_state, 3'd4);
      chk("win_submit_clear", bus_a.o_clear_entry, 1'b0);

      // 12 wrong guesses: BCD boundary past ten
      bus_a.i_new_game = 1; cyc(); bus_a.i_new_game = 0;
      chk("ng2_led",  bus_a.o_led, 8'h00);
      chk("ng2_hint", bus_a.o_hint, 2'b00);
      bus_a.i_entry = 16'h8000; bus_a.i_submit = 1; cyc(); bus_a.i_submit = 0;
      for (int i = 1; i <= 12; i++) begin
         bus_a.i_entry = 16'(i); bus_a.i_submit = 1; cyc(); bus_a.i_submit = 0; cyc();
      end
      chk("g12_attempts", bus_a.o_attempts, 5'd12);
      chk("g12_bcd",      bus_a.o_attempts_bcd, 8'h12);
      chk("g12_state",    bus_a.o_state, 3'd2);

      // 6: new_game wins over submit in the same cycle
      bus_a.i_entry = 16'h1111; bus_a.i_new_game = 1; bus_a.i_submit = 1; cyc();
      bus_a.i_new_game = 0; bus_a.i_submit = 0;
      chk("ngsub_state",    bus_a.o_state, 3'd1);
      chk("ngsub_attempts", bus_a.o_attempts, 5'd0);
      chk("ngsub_hint",     bus_a.o_hint, 2'b00);

      // 5: dut_b, submit ignored in IDLE, then two misses -> LOSE
      bus_b.i_entry = 16'h0005; bus_b.i_submit = 1; cyc(); bus_b.i_submit = 0;
      chk("b_idle_state", bus_b.o_state, 3'd0);
      chk("b_idle_clear", bus_b.o_clear_entry, 1'b0);
      bus_b.i_new_game = 1; cyc(); bus_b.i_new_game = 0;
      bus_b.i_entry = 16'h00FF; bus_b.i_submit = 1; cyc(); bus_b.i_submit = 0;
      bus_b.i_entry = 16'h0100; bus_b.i_submit = 1; cyc(); bus_b.i_submit = 0; cyc();
      chk("b_g1_hint",  bus_b.o_hint, 2'b10);
      chk("b_g1_state", bus_b.o_state, 3'd2);
      bus_b.i_entry = 16'h0001; bus_b.i_submit = 1; cyc(); bus_b.i_submit = 0; cyc();
      chk("b_lose_state", bus_b.o_state, 3'd5);
      chk("b_lose_hint",  bus_b.o_hint, 2'b01);
      chk("b_lose_led",   bus_b.o_led, 8'h0F);
      chk("b_lose_over",  bus_b.o_game_over, 1'b1);
      bus_b.i_submit = 1; bus_b.i_tick = 1; cyc(); bus_b.i_submit = 0; bus_b.i_tick = 0;
      chk("b_lose_sub_state", bus_b.o_state, 3'd5);
      chk("b_lose_sub_att",   bus_b.o_attempts, 5'd2);
      chk("b_lose_sub_clear", bus_b.o_clear_entry, 1'b0);
      chk("b_lose_tick_led",  bus_b.o_led, 8'h0F);

      // 6: reset mid-GUESS on dut_a
      bus_a.i_entry = 16'h1234; bus_a.i_submit = 1; cyc(); bus_a.i_submit = 0;
      bus_a.i_entry = 16'h0001; bus_a.i_submit = 1; cyc(); bus_a.i_submit = 0; cyc();
      chk("pre_rst_state", bus_a.o_state, 3'd2);
      rst = 1; cyc(); rst = 0;
      chk("mid_rst_state", bus_a.o_state, 3'd0);
      chk("mid_rst_att",   bus_a.o_attempts, 5'd0);
      chk("mid_rst_bcd",   bus_a.o_attempts_bcd, 8'h00);
      chk("mid_rst_hint",  bus_a.o_hint, 2'b00);
      chk("mid_rst_flags", {bus_a.o_game_over, bus_a.o_entry_en, bus_a.o_active_player, bus_a.o_clear_entry}, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
